// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT-line paths: FSM states, CRC16 constants and serial CRC step.
package sd_dat_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StCrc,
    StEndb
  } dat_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int unsigned CRC_BITS   = 16;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        END_BIT    = 1'b1;

  // One bit of CRC16-CCITT, MSB-first, no reflection.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/dat_crc16_serial.sv
// Serial CRC16-CCITT generator for one DAT line; shared by receive and transmit paths.
module dat_crc16_serial
  import sd_dat_pkg::*;
(
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc <= 16'h0000;
    end else if (clear) begin
      crc <= 16'h0000;
    end else if (shift_en) begin
      crc <= crc16_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/wrapper_serial_paralelo.sv
// SD DAT-line receiver: detects the start bit, deserialises one block into N-bit words,
// then checks per-line CRC16 and the end bit.
module wrapper_serial_paralelo
  import sd_dat_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned M           = 1,
  parameter int unsigned BLOCK_WORDS = 512
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [M-1:0] dat_in,
  output logic [N-1:0] parallel,
  output logic         word_valid,
  output logic         busy,
  output logic         complete,
  output logic         crc_error,
  output logic         end_error
);

  localparam int unsigned BitsPerWord = N / M;
  localparam int unsigned BitCntW     = (BitsPerWord > 1) ? $clog2(BitsPerWord) : 1;
  localparam int unsigned WordCntW    = $clog2(BLOCK_WORDS + 1);

  dat_state_e          state_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic [WordCntW-1:0] word_cnt_q;
  logic [3:0]          crc_cnt_q;
  logic [N-M-1:0]      shreg_q;
  logic                crc_fail_q;

  logic [15:0]  crc_line [M];
  logic [M-1:0] crc_exp_bits;
  logic [N-1:0] shift_word;
  logic         start_det;
  logic         crc_shift;
  logic         crc_mismatch;

  assign start_det  = (state_q == StIdle) && enable && (dat_in == {M{START_BIT}});
  assign crc_shift  = (state_q == StData) && enable;
  assign shift_word = {shreg_q, dat_in};

  for (genvar i = 0; i < M; i++) begin : g_crc
    dat_crc16_serial u_crc (
      .sd_clock (sd_clock),
      .reset    (reset),
      .clear    (start_det),
      .shift_en (crc_shift),
      .bit_in   (dat_in[i]),
      .crc      (crc_line[i])
    );
  end

  // Computed CRCs are frozen during StCrc, so bit crc_cnt_q is sent MSB first.
  always_comb begin
    crc_exp_bits = '0;
    for (int i = 0; i < M; i++) begin
      crc_exp_bits[i] = crc_line[i][4'(CRC_BITS - 1) - crc_cnt_q];
    end
  end

  assign crc_mismatch = |(crc_exp_bits ^ dat_in);

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      crc_cnt_q  <= '0;
      shreg_q    <= '0;
      crc_fail_q <= 1'b0;
      parallel   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      complete   <= 1'b0;
      crc_error  <= 1'b0;
      end_error  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      complete   <= 1'b0;
      if (state_q != StIdle && !enable) begin
        // Abort: no further pulses, error outputs keep their value.
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_det) begin
              state_q    <= StData;
              busy       <= 1'b1;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
              crc_cnt_q  <= '0;
              crc_fail_q <= 1'b0;
              crc_error  <= 1'b0;
              end_error  <= 1'b0;
            end
          end
          StData: begin
            shreg_q <= shift_word[N-M-1:0];
            if (bit_cnt_q == BitCntW'(BitsPerWord - 1)) begin
              bit_cnt_q  <= '0;
              parallel   <= shift_word;
              word_valid <= 1'b1;
              word_cnt_q <= word_cnt_q + WordCntW'(1);
              if (word_cnt_q == WordCntW'(BLOCK_WORDS - 1)) begin
                state_q   <= StCrc;
                crc_cnt_q <= '0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
          StCrc: begin
            if (crc_mismatch) begin
              crc_fail_q <= 1'b1;
            end
            crc_cnt_q <= crc_cnt_q + 4'd1;
            if (crc_cnt_q == 4'(CRC_BITS - 1)) begin
              state_q <= StEndb;
            end
          end
          StEndb: begin
            crc_error <= crc_fail_q;
            end_error <= (dat_in != {M{END_BIT}});
            complete  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wrapper_serial_paralelo.sv
// Randomised self-checking bench for wrapper_serial_paralelo with 1-line and 4-line instances.
module tb_wrapper_serial_paralelo;

  logic       sd_clock = 1'b0;
  logic       reset    = 1'b0;
  logic       en1      = 1'b0;
  logic       en4      = 1'b0;
  logic [0:0] dat1     = 1'b1;
  logic [3:0] dat4     = 4'hF;

  logic [7:0] par1, par4;
  logic       wv1, busy1, cmp1, ce1, ee1;
  logic       wv4, busy4, cmp4, ce4, ee4;

  always #5 sd_clock = ~sd_clock;

  wrapper_serial_paralelo #(.N(8), .M(1), .BLOCK_WORDS(2)) dut1 (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .enable     (en1),
    .dat_in     (dat1),
    .parallel   (par1),
    .word_valid (wv1),
    .busy       (busy1),
    .complete   (cmp1),
    .crc_error  (ce1),
    .end_error  (ee1)
  );

  wrapper_serial_paralelo #(.N(8), .M(4), .BLOCK_WORDS(2)) dut4 (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .enable     (en4),
    .dat_in     (dat4),
    .parallel   (par4),
    .word_valid (wv4),
    .busy       (busy4),
    .complete   (cmp4),
    .crc_error  (ce4),
    .end_error  (ee4)
  );

  int errors = 0;
  int checks = 0;
  int sel    = 1;

  // Expected outputs of the selected instance after the next sampling point.
  logic [7:0] exp_par;
  logic       exp_wv, exp_busy, exp_cmp, exp_ce, exp_ee;
  logic [7:0] slot_par [2];
  logic       slot_ce  [2];
  logic       slot_ee  [2];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (M=%0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  task automatic check_outputs();
    if (sel == 1) begin
      chk("parallel", 16'(par1), 16'(exp_par));
      chk("word_valid", 16'(wv1), 16'(exp_wv));
      chk("busy", 16'(busy1), 16'(exp_busy));
      chk("complete", 16'(cmp1), 16'(exp_cmp));
      chk("crc_error", 16'(ce1), 16'(exp_ce));
      chk("end_error", 16'(ee1), 16'(exp_ee));
    end else begin
      chk("parallel", 16'(par4), 16'(exp_par));
      chk("word_valid", 16'(wv4), 16'(exp_wv));
      chk("busy", 16'(busy4), 16'(exp_busy));
      chk("complete", 16'(cmp4), 16'(exp_cmp));
      chk("crc_error", 16'(ce4), 16'(exp_ce));
      chk("end_error", 16'(ee4), 16'(exp_ee));
    end
  endtask

  task automatic tick(input logic [3:0] d, input logic en);
    if (sel == 1) begin
      dat1 = d[0:0];
      en1  = en;
      en4  = 1'b0;
      dat4 = 4'hF;
    end else begin
      dat4 = d;
      en4  = en;
      en1  = 1'b0;
      dat1 = 1'b1;
    end
    @(posedge sd_clock);
    #1;
    check_outputs();
    exp_wv  = 1'b0;
    exp_cmp = 1'b0;
  endtask

  task automatic select(input int m);
    int s;
    s = (sel == 1) ? 0 : 1;
    slot_par[s] = exp_par;
    slot_ce[s]  = exp_ce;
    slot_ee[s]  = exp_ee;
    sel = m;
    s = (m == 1) ? 0 : 1;
    exp_par  = slot_par[s];
    exp_ce   = slot_ce[s];
    exp_ee   = slot_ee[s];
    exp_wv   = 1'b0;
    exp_busy = 1'b0;
    exp_cmp  = 1'b0;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    // Long division by x^16+x^12+x^5+1, one message bit at a time.
    logic top;
    top = c[15] ^ b;
    c   = c << 1;
    if (top) c = c ^ 16'h1021;
    return c;
  endfunction

  function automatic logic [15:0] line_crc(input logic [7:0] a, input logic [7:0] b,
                                           input int m, input int line);
    logic [15:0] c;
    logic [7:0]  w;
    c = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? a : b;
      for (int g = 0; g < 8 / m; g++) c = crc_step(c, w[8 - m * (g + 1) + line]);
    end
    return c;
  endfunction

  // Idle cycles: never an all-low pattern while enabled.
  task automatic idle(input int n);
    logic       en;
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      en = 1'($urandom_range(0, 1));
      if (en) d = (sel == 1) ? 4'h1 : 4'($urandom_range(1, 15));
      else    d = 4'($urandom_range(0, 15));
      tick(d, en);
    end
  endtask

  // pos counts edges after the start bit; abort_pos drops enable on that edge (0 = never).
  task automatic send_frame(input int m, input logic [7:0] w0, input logic [7:0] w1,
                            input int flip_bit, input int flip_line, input bit end_bad,
                            input int abort_pos, input bit reset_in_crc);
    logic [15:0] crcs [4];
    logic [7:0]  ws   [2];
    logic [3:0]  d;
    int          pos;
    int          v;
    select(m);
    ws[0] = w0;
    ws[1] = w1;
    for (int i = 0; i < 4; i++) crcs[i] = (i < m) ? line_crc(w0, w1, m, i) : 16'h0;
    exp_busy = 1'b1;
    exp_ce   = 1'b0;
    exp_ee   = 1'b0;
    tick(4'h0, 1'b1);
    pos = 0;
    for (int k = 0; k < 2; k++) begin
      for (int g = 0; g < 8 / m; g++) begin
        pos++;
        v = int'(ws[k]);
        d = 4'((v >> (8 - m * (g + 1))) & ((1 << m) - 1));
        if (pos == abort_pos) begin
          exp_busy = 1'b0;
          tick(d, 1'b0);
          return;
        end
        if (g == 8 / m - 1) begin
          exp_wv  = 1'b1;
          exp_par = ws[k];
        end
        tick(d, 1'b1);
      end
    end
    for (int j = 0; j < 16; j++) begin
      pos++;
      d = 4'h0;
      for (int i = 0; i < m; i++) d[i] = crcs[i][15 - j] ^ ((j == flip_bit) && (i == flip_line));
      if (pos == abort_pos) begin
        exp_busy = 1'b0;
        tick(d, 1'b0);
        return;
      end
      if (reset_in_crc && j == 5) begin
        #2;
        reset = 1'b0;
        #1;
        exp_par = 8'h00; exp_wv = 1'b0; exp_busy = 1'b0;
        exp_cmp = 1'b0;  exp_ce = 1'b0; exp_ee   = 1'b0;
        slot_par[0] = 8'h00; slot_par[1] = 8'h00;
        slot_ce[0]  = 1'b0;  slot_ce[1]  = 1'b0;
        slot_ee[0]  = 1'b0;  slot_ee[1]  = 1'b0;
        check_outputs();
        tick(d, 1'b1);
        reset = 1'b1;
        return;
      end
      tick(d, 1'b1);
    end
    pos++;
    if (end_bad) d = (m == 1) ? 4'h0 : 4'($urandom_range(0, 14));
    else         d = (m == 1) ? 4'h1 : 4'hF;
    if (pos == abort_pos) begin
      exp_busy = 1'b0;
      tick(d, 1'b0);
      return;
    end
    exp_busy = 1'b0;
    exp_cmp  = 1'b1;
    exp_ce   = (flip_bit >= 0);
    exp_ee   = end_bad;
    tick(d, 1'b1);
  endtask

  initial begin
    logic [15:0] c;
    logic [7:0]  msg;
    int          m, fb, ab;
    bit          eb;
    exp_par = 8'h00; exp_wv = 1'b0; exp_busy = 1'b0;
    exp_cmp = 1'b0;  exp_ce = 1'b0; exp_ee   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slot_par[i] = 8'h00; slot_ce[i] = 1'b0; slot_ee[i] = 1'b0;
    end

    // Reset state of both instances.
    #12;
    sel = 1; check_outputs();
    sel = 4; check_outputs();
    sel = 1;
    reset = 1'b1;

    // Pin the reference CRC: CRC16-CCITT(init 0) of "123456789" is 0x31C3; a single 1 gives 0x1021.
    c = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      msg = 8'(8'h31 + i);
      for (int b = 7; b >= 0; b--) c = crc_step(c, msg[b]);
    end
    chk("model_crc_check_string", c, 16'h31C3);
    chk("model_crc_single_one", crc_step(16'h0000, 1'b1), 16'h1021);

    // 1-line good frame, CRC-flipped frame, bad end bit, then good frame clears errors.
    select(1);
    idle(3);
    send_frame(1, 8'hA5, 8'h3C, -1, 0, 1'b0, 0, 1'b0);
    chk("t1_last_word_literal", 16'(par1), 16'h003C);
    idle(2);
    send_frame(1, 8'hA5, 8'h3C, 7, 0, 1'b0, 0, 1'b0);
    chk("t2_crc_error_literal", 16'(ce1), 16'h0001);
    idle(2);
    send_frame(1, 8'hA5, 8'h3C, -1, 0, 1'b1, 0, 1'b0);
    chk("t3_end_error_literal", 16'(ee1), 16'h0001);
    send_frame(1, 8'h5A, 8'hC3, -1, 0, 1'b0, 0, 1'b0);

    // 4-line frame.
    idle(2);
    send_frame(4, 8'h12, 8'h34, -1, 0, 1'b0, 0, 1'b0);
    chk("t4_last_word_literal", 16'(par4), 16'h0034);

    // Abort after 5 data bits, then a good frame.
    send_frame(1, 8'hF0, 8'h0F, -1, 0, 1'b0, 6, 1'b0);
    idle(2);
    send_frame(1, 8'h81, 8'h7E, -1, 0, 1'b0, 0, 1'b0);

    // Randomised frames on both widths with optional faults and aborts.
    for (int r = 0; r < 40; r++) begin
      m  = ($urandom_range(0, 1) == 0) ? 1 : 4;
      fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      eb = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 16 / m + 17)) : 0;
      send_frame(m, 8'($urandom), 8'($urandom), fb, int'($urandom_range(0, m - 1)), eb, ab, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end

    // Reset mid-CRC, then no start on idle-high or on a partial low.
    send_frame(1, 8'h66, 8'h99, -1, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) tick(4'h1, 1'b1);
    select(4);
    for (int i = 0; i < 3; i++) tick(4'b1110, 1'b1);
    send_frame(4, 8'hDE, 8'hAD, -1, 0, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
